// File: rtl/lsq_mem_issuer_pkg.sv
// Shared types for the LSQ memory issuer: LSQ entry layout, load/store
// funct3 encodings and the issuer state enum.
package lsq_mem_issuer_pkg;

   localparam int LSQ_PREG_BITS = 6;
   localparam int LSQ_ROB_BITS  = 5;

   typedef struct packed {
      logic                     is_store;
      logic [2:0]               funct3;
      logic [LSQ_PREG_BITS-1:0] ps1;
      logic [LSQ_PREG_BITS-1:0] ps2;
      logic [LSQ_PREG_BITS-1:0] pd;
      logic [31:0]              imm;
      logic [LSQ_ROB_BITS-1:0]  rob_idx;
   } lsq_entry_t;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } mem_funct3_t;

   typedef enum logic [1:0] {
      ISS_IDLE,
      ISS_WAIT_RESP,
      ISS_DRAIN
   } issuer_state_t;

endpackage

// File: rtl/lsq_mem_issuer_load_align.sv
// Load result alignment: selects the addressed lane of the read word and
// sign- or zero-extends it according to funct3.
module lsq_mem_issuer_load_align
   import lsq_mem_issuer_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   result = {24'h000000, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   result = {16'h0000, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/lsq_mem_issuer.sv
// LSQ head consumer: issues one dcache request at a time, pops the LSQ and
// broadcasts on the CDB. Define LSQ_ISSUER_PERF_EN to add perf counters.
module lsq_mem_issuer
   import lsq_mem_issuer_pkg::*;
#(
   parameter int PREG_BITS = LSQ_PREG_BITS,
   parameter int ROB_BITS  = LSQ_ROB_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mispredict,
   input  logic                 lsq_empty,
   input  lsq_entry_t           lsq_head,
   output logic                 arbiter_pop,
   output logic [PREG_BITS-1:0] prf_rs1_addr,
   output logic [PREG_BITS-1:0] prf_rs2_addr,
   input  logic [31:0]          prf_rs1_data,
   input  logic [31:0]          prf_rs2_data,
   input  logic                 prf_rs1_ready,
   input  logic                 prf_rs2_ready,
   input  logic [ROB_BITS-1:0]  rob_head_idx,
   output logic [31:0]          dmem_addr,
   output logic [3:0]           dmem_rmask,
   output logic [3:0]           dmem_wmask,
   output logic [31:0]          dmem_wdata,
   input  logic [31:0]          dmem_rdata,
   input  logic                 dmem_resp,
   output logic                 cdb_valid,
   output logic [ROB_BITS-1:0]  cdb_rob_idx,
   output logic [PREG_BITS-1:0] cdb_pd,
   output logic                 cdb_rd_we,
   output logic [31:0]          cdb_data
`ifdef LSQ_ISSUER_PERF_EN
   ,
   output logic [31:0]          perf_loads,
   output logic [31:0]          perf_stores,
   output logic [31:0]          perf_stall_cycles
`endif
);

   issuer_state_t        state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [3:0]           rmask_q, rmask_d;
   logic [3:0]           wmask_q, wmask_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [1:0]           off_q, off_d;
   logic [2:0]           funct3_q, funct3_d;
   logic [PREG_BITS-1:0] pd_q, pd_d;
   logic [ROB_BITS-1:0]  rob_q, rob_d;
   logic                 is_store_q, is_store_d;
   logic                 cdb_valid_q, cdb_valid_d;
   logic                 cdb_rd_we_q, cdb_rd_we_d;
   logic [31:0]          cdb_data_q, cdb_data_d;
   logic [PREG_BITS-1:0] cdb_pd_q, cdb_pd_d;
   logic [ROB_BITS-1:0]  cdb_rob_q, cdb_rob_d;

   logic                 issue_ok;
   logic [31:0]          eff;
   logic [3:0]           mask_new;
   logic [31:0]          load_val;

   assign prf_rs1_addr = lsq_head.ps1;
   assign prf_rs2_addr = lsq_head.ps2;

   // Stores additionally wait for rs2 and for being the oldest ROB entry.
   always_comb begin
      issue_ok = !lsq_empty && !mispredict && prf_rs1_ready &&
                 (!lsq_head.is_store ||
                  (prf_rs2_ready && (lsq_head.rob_idx == rob_head_idx)));
      eff      = prf_rs1_data + lsq_head.imm;
      case (lsq_head.funct3)
         F3_B, F3_BU: mask_new = 4'b0001 << eff[1:0];
         F3_H, F3_HU: mask_new = 4'b0011 << eff[1:0];
         default:     mask_new = 4'b1111;
      endcase
   end

   lsq_mem_issuer_load_align u_align (
      .rdata  (dmem_rdata),
      .offset (off_q),
      .funct3 (funct3_q),
      .result (load_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ISS_IDLE;
         addr_q      <= '0;
         rmask_q     <= '0;
         wmask_q     <= '0;
         wdata_q     <= '0;
         off_q       <= '0;
         funct3_q    <= '0;
         pd_q        <= '0;
         rob_q       <= '0;
         is_store_q  <= 1'b0;
         cdb_valid_q <= 1'b0;
         cdb_rd_we_q <= 1'b0;
         cdb_data_q  <= '0;
         cdb_pd_q    <= '0;
         cdb_rob_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rmask_q     <= rmask_d;
         wmask_q     <= wmask_d;
         wdata_q     <= wdata_d;
         off_q       <= off_d;
         funct3_q    <= funct3_d;
         pd_q        <= pd_d;
         rob_q       <= rob_d;
         is_store_q  <= is_store_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_rd_we_q <= cdb_rd_we_d;
         cdb_data_q  <= cdb_data_d;
         cdb_pd_q    <= cdb_pd_d;
         cdb_rob_q   <= cdb_rob_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ISS_IDLE:      if (issue_ok) state_d = ISS_WAIT_RESP;
         ISS_WAIT_RESP: begin
            if (dmem_resp)       state_d = ISS_IDLE;
            else if (mispredict) state_d = ISS_DRAIN;
         end
         ISS_DRAIN:     if (dmem_resp) state_d = ISS_IDLE;
         default:       state_d = ISS_IDLE;
      endcase
   end

   // Request/CDB datapath; the CDB result is captured at resp since rdata
   // is only valid in that cycle.
   always_comb begin
      arbiter_pop = (state_q == ISS_WAIT_RESP) && dmem_resp && !mispredict;
      addr_d      = addr_q;
      rmask_d     = rmask_q;
      wmask_d     = wmask_q;
      wdata_d     = wdata_q;
      off_d       = off_q;
      funct3_d    = funct3_q;
      pd_d        = pd_q;
      rob_d       = rob_q;
      is_store_d  = is_store_q;
      cdb_valid_d = 1'b0;
      cdb_rd_we_d = 1'b0;
      cdb_data_d  = '0;
      cdb_pd_d    = '0;
      cdb_rob_d   = '0;
      if ((state_q == ISS_IDLE) && issue_ok) begin
         addr_d     = {eff[31:2], 2'b00};
         rmask_d    = lsq_head.is_store ? 4'b0000 : mask_new;
         wmask_d    = lsq_head.is_store ? mask_new : 4'b0000;
         wdata_d    = lsq_head.is_store ? (prf_rs2_data << {eff[1:0], 3'b000}) : '0;
         off_d      = eff[1:0];
         funct3_d   = lsq_head.funct3;
         pd_d       = lsq_head.pd;
         rob_d      = lsq_head.rob_idx;
         is_store_d = lsq_head.is_store;
      end
      if ((state_q != ISS_IDLE) && dmem_resp) begin
         rmask_d = '0;
         wmask_d = '0;
      end
      if (arbiter_pop) begin
         cdb_valid_d = 1'b1;
         cdb_rd_we_d = !is_store_q;
         cdb_data_d  = is_store_q ? '0 : load_val;
         cdb_pd_d    = pd_q;
         cdb_rob_d   = rob_q;
      end
   end

   assign dmem_addr   = addr_q;
   assign dmem_rmask  = rmask_q;
   assign dmem_wmask  = wmask_q;
   assign dmem_wdata  = wdata_q;
   assign cdb_valid   = cdb_valid_q;
   assign cdb_rob_idx = cdb_rob_q;
   assign cdb_pd      = cdb_pd_q;
   assign cdb_rd_we   = cdb_rd_we_q;
   assign cdb_data    = cdb_data_q;

`ifdef LSQ_ISSUER_PERF_EN
   logic [31:0] perf_loads_q, perf_loads_d;
   logic [31:0] perf_stores_q, perf_stores_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_loads_d  = perf_loads_q;
      perf_stores_d = perf_stores_q;
      perf_stall_d  = perf_stall_q;
      if (arbiter_pop && !is_store_q) perf_loads_d  = perf_loads_q + 32'd1;
      if (arbiter_pop && is_store_q)  perf_stores_d = perf_stores_q + 32'd1;
      if ((state_q == ISS_IDLE) && !lsq_empty && !issue_ok)
         perf_stall_d = perf_stall_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_loads_q  <= '0;
         perf_stores_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_loads_q  <= perf_loads_d;
         perf_stores_q <= perf_stores_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_loads        = perf_loads_q;
   assign perf_stores       = perf_stores_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
